// File: rtl/baud_gen_param.sv
// baud_gen_param: SPART baud / oversample tick generator.
//
// A down-counter reloaded from the active divisor produces one rx_tick
// every divisor+1 clocks. A TX phase counter turns every OVERSAMPLE
// rx_ticks into one tx_tick. An RX phase counter marks the mid-bit
// sample point (rx_mid_tick) and can be realigned by rx_sync.
//
// The divisor is double-buffered: low/high byte writes land in a shadow
// register, and the high-byte write triggers a commit of the whole shadow
// to the active divisor one cycle later. The commit restarts the counters
// so the new rate starts from a clean phase.
//
// Optional feature macro: FRAC_BAUD_EN
//   When defined, ioaddr 2'b01 writes a 4-bit fraction (committed together
//   with the high byte). A 4-bit accumulator adds the fraction on every
//   counter reload; on carry-out the reload uses divisor+1, giving an
//   average rx_tick period of divisor+1+frac/16 clocks.
//   The divisor+1 reload wraps to 0 at the all-ones divisor.
//   When undefined, ioaddr 2'b01 writes are ignored.

module baud_gen_param #(
    parameter int          DIV_WIDTH  = 16,
    parameter int          OVERSAMPLE = 16,
    parameter logic [15:0] DIV_RESET  = 16'd162
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] baud_gen,
    input  logic       baud_load,
    input  logic [1:0] ioaddr,
    input  logic       gen_en,
    input  logic       rx_sync,
    output logic       rx_tick,
    output logic       tx_tick,
    output logic       rx_mid_tick
);

    localparam int                   PH_W     = $clog2(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_RESET[DIV_WIDTH-1:0];
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]      PH_MAX   = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]      PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0]      PH_ZERO  = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]      PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] r_shadow;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_counter;
    logic [PH_W-1:0]      r_tx_phase;
    logic [PH_W-1:0]      r_rx_phase;
    logic                 r_commit;
    logic                 r_rx_tick;
    logic                 r_tx_tick;
    logic                 r_rx_mid_tick;

    logic                 w_wr_lo;
    logic                 w_wr_hi;
    logic                 w_cnt_zero;
    logic [DIV_WIDTH-1:0] w_reload;

    assign w_wr_lo    = baud_load && (ioaddr == 2'b10);
    assign w_wr_hi    = baud_load && (ioaddr == 2'b11);
    assign w_cnt_zero = (r_counter == DIV_ZERO);

`ifdef FRAC_BAUD_EN
    logic       w_wr_frac;
    logic [3:0] r_frac_shadow;
    logic [3:0] r_frac;
    logic [3:0] r_acc;
    logic [4:0] w_acc_sum;

    assign w_wr_frac = baud_load && (ioaddr == 2'b01);
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_reload  = w_acc_sum[4] ? (r_div + DIV_ONE) : r_div;

    // Fraction shadow register, written independently of the divisor bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frac_shadow <= 4'd0;
        end else if (w_wr_frac) begin
            r_frac_shadow <= baud_gen[3:0];
        end else begin
            r_frac_shadow <= r_frac_shadow;
        end
    end
`else
    assign w_reload = r_div;
`endif

    // Shadow divisor bytes and the one-cycle-delayed commit request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= DIV_RST;
            r_commit <= 1'b0;
        end else begin
            r_commit <= w_wr_hi;
            if (w_wr_lo) begin
                r_shadow[7:0] <= baud_gen;
            end else if (w_wr_hi) begin
                r_shadow[DIV_WIDTH-1:8] <= baud_gen[DIV_WIDTH-9:0];
            end else begin
                r_shadow <= r_shadow;
            end
        end
    end

    // Rate counter, phase counters and registered tick outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= DIV_RST;
            r_counter     <= DIV_RST;
            r_tx_phase    <= PH_MAX;
            r_rx_phase    <= PH_ZERO;
            r_rx_tick     <= 1'b0;
            r_tx_tick     <= 1'b0;
            r_rx_mid_tick <= 1'b0;
`ifdef FRAC_BAUD_EN
            r_frac        <= 4'd0;
            r_acc         <= 4'd0;
`endif
        end else if (r_commit) begin
            // Commit restarts everything; it overrides a pending counter==0.
            r_div         <= r_shadow;
            r_counter     <= r_shadow;
            r_tx_phase    <= PH_MAX;
            r_rx_phase    <= PH_ZERO;
            r_rx_tick     <= 1'b0;
            r_tx_tick     <= 1'b0;
            r_rx_mid_tick <= 1'b0;
`ifdef FRAC_BAUD_EN
            r_frac        <= r_frac_shadow;
            r_acc         <= 4'd0;
`endif
        end else if (!gen_en) begin
            // Parked so the first rx_tick after enable is divisor+1 clocks out.
            r_counter     <= r_div;
            r_tx_phase    <= PH_MAX;
            r_rx_phase    <= PH_ZERO;
            r_rx_tick     <= 1'b0;
            r_tx_tick     <= 1'b0;
            r_rx_mid_tick <= 1'b0;
`ifdef FRAC_BAUD_EN
            r_acc         <= 4'd0;
`endif
        end else if (w_cnt_zero) begin
            r_counter     <= w_reload;
            r_rx_tick     <= 1'b1;
            r_rx_mid_tick <= !rx_sync && (r_rx_phase == PH_MID);
            r_rx_phase    <= rx_sync ? PH_ZERO : (r_rx_phase + PH_ONE);
`ifdef FRAC_BAUD_EN
            r_acc         <= w_acc_sum[3:0];
`endif
            if (r_tx_phase == PH_ZERO) begin
                r_tx_phase <= PH_MAX;
                r_tx_tick  <= 1'b1;
            end else begin
                r_tx_phase <= r_tx_phase - PH_ONE;
                r_tx_tick  <= 1'b0;
            end
        end else begin
            r_counter     <= r_counter - DIV_ONE;
            r_rx_tick     <= 1'b0;
            r_tx_tick     <= 1'b0;
            r_rx_mid_tick <= 1'b0;
            r_rx_phase    <= rx_sync ? PH_ZERO : r_rx_phase;
        end
    end

    assign rx_tick     = r_rx_tick;
    assign tx_tick     = r_tx_tick;
    assign rx_mid_tick = r_rx_mid_tick;

endmodule

// File: doc/baud_gen_param.md
Name: baud_gen_param

Overview:
- Parametrised next-generation SPART baud/sample tick generator.
- Takes divisor bytes from the SPART bus and produces single-cycle oversample ticks (rx_tick), bit ticks (tx_tick) and a mid-bit sample strobe (rx_mid_tick).
- Adds several things the previous generator lacked: divisor width and oversample ratio as parameters, a double-buffered divisor with glitch-free commit, a generator enable, and RX phase resync on start-bit detect.
- Sits between the SPART bus interface and the tx/rx shifters.

Parameters:
- DIV_WIDTH, 16, active divisor width in bits; legal range 9..16; bits above DIV_WIDTH in the high byte are dropped.
- OVERSAMPLE, 16, rx_ticks per bit; power of two, range 4..32.
- DIV_RESET, 16'd162, divisor value loaded at reset (truncated to DIV_WIDTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_gen  in  8  divisor data byte.
- baud_load  in  1  write strobe for baud_gen, qualified by ioaddr.
- ioaddr  in  2  register select: 2'b10 = low byte, 2'b11 = high byte.
- gen_en  in  1  generator enable.
- rx_sync  in  1  start-bit detect pulse from the receiver; realigns the RX phase.
- rx_tick  out  1  oversample tick, one cycle wide.
- tx_tick  out  1  bit tick (every OVERSAMPLE rx_ticks), one cycle wide.
- rx_mid_tick  out  1  mid-bit sample strobe, one cycle wide.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0.
  - shadow and active divisor = DIV_RESET.
  - counter = DIV_RESET.
  - tx_phase = OVERSAMPLE-1.
  - rx_phase = 0.
- All outputs are registered. A tick appears the cycle after the counter condition that produces it.
- Divisor loading:
  - baud_load & ioaddr==10: write shadow[7:0].
  - baud_load & ioaddr==11: write shadow[DIV_WIDTH-1:8], then commit the full shadow to the active divisor on the next cycle.
  - Commit also sets counter = new divisor and tx_phase = OVERSAMPLE-1, and clears rx_phase.
  - Writing the low byte alone never changes the active rate.
  - baud_load with ioaddr 00/01 is ignored.
  - Loads never stall counting.
- Counter: down-counter of DIV_WIDTH bits.
  - At 0: reload the active divisor and pulse rx_tick. Otherwise decrement.
  - rx_tick period = divisor+1 clocks.
  - Divisor 0: rx_tick is high every cycle.
- TX phase: decrements on each rx_tick.
  - At 0 with an rx_tick: pulse tx_tick and reload OVERSAMPLE-1.
  - tx_tick period = OVERSAMPLE*(divisor+1) clocks.
- RX phase: a log2(OVERSAMPLE)-bit counter that increments on each rx_tick and wraps to 0.
  - rx_mid_tick is pulsed with the rx_tick for which the pre-increment rx_phase == OVERSAMPLE/2-1.
- rx_sync: forces rx_phase to 0 that cycle. Priority over an rx_tick in the same cycle; rx_mid_tick is suppressed that cycle.
- gen_en=0:
  - counter held at the active divisor, tx_phase held at OVERSAMPLE-1, rx_phase held at 0.
  - All ticks 0.
  - Divisor writes and commits still occur.
- On gen_en rising, the first rx_tick occurs divisor+1 cycles later.
- Simultaneous commit and counter==0: the commit wins, no tick that cycle.
- Reset mid-operation: immediate return to reset values. No partial tick.

Optional Feature:
FRAC_BAUD_EN
- Defined:
  - Adds a 4-bit fraction register, written by baud_load & ioaddr==01 (baud_gen[3:0]), double-buffered with the high-byte commit.
  - A 4-bit accumulator adds the fraction on each counter reload.
  - On carry-out, the reload uses divisor+1.
  - Average rx_tick period = divisor+1+frac/16 clocks.
  - The accumulator clears on reset, commit and gen_en=0.
- Undefined: ioaddr 01 writes are ignored and the fixed-divisor behaviour applies.

Test Plan:
- Reset, then gen_en=1 with defaults -> first rx_tick 163 cycles after enable; rx_tick every 163 cycles; tx_tick every 2608 cycles; ticks are 1 cycle wide.
- Write low=0x04, then wait 1000 cycles -> the rate is unchanged (163-cycle period). Then write high=0x00 -> from the commit, rx_tick every 5 cycles; tx_tick every 80.
- Divisor 0 (low 0x00, high 0x00) -> rx_tick continuously 1; tx_tick 1 every 16th cycle.
- Divisor 4, rx_sync pulsed mid-bit -> rx_mid_tick on the 8th rx_tick after sync (40 cycles later); no rx_mid_tick in the sync cycle.
- gen_en dropped mid-bit, then raised after 50 cycles -> no ticks while low; tx_tick is OVERSAMPLE*(div+1) cycles after re-enable.
- FRAC_BAUD_EN with divisor 4, frac 8 -> over 16 rx_ticks, 8 periods of 6 cycles and 8 of 5 (88 cycles total); rst_n asserted mid-count clears all outputs asynchronously.
